multiplier_product_accumulator: RTL and testbench



---
 rtl/mult_acc_pkg.sv | 7 +
 rtl/acc_add_sat.sv | 20 ++
 rtl/multiplier_product_accumulator.sv | 62 ++++++
 tb/tb_multiplier_product_accumulator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: shared state encoding and default sizing for the product accumulator
package mult_acc_pkg;
    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;
    localparam int DEF_PROD_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_COUNT = 4;
endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: accumulator adder with carry-out; ACC_SATURATE_EN clamps to all-ones on carry
module acc_add_sat
    import mult_acc_pkg::*;
#(
    parameter int W = DEF_ACC_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W-1:0] raw;
    assign {carry, raw} = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
    // once clamped, any further add carries again, so the clamp holds for the rest of the result
    assign sum = carry ? {W{1'b1}} : raw;
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/multiplier_product_accumulator.sv
// multiplier_product_accumulator: sums COUNT products into one result on a valid/ready channel (ACC_SATURATE_EN selects clamping)
module multiplier_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int COUNT = DEF_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_overflow,
    output logic [7:0]            beat_count
);
    state_t state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic carry;
    logic ovf;
    logic accept;
    logic last;
    assign in_ready = state == ACCUM;
    assign out_valid = state == HOLD;
    assign accept = in_valid && in_ready;
    assign last = beat_count == 8'(COUNT - 1);
    acc_add_sat #(.W(ACC_WIDTH)) u_add (
        .a(acc),
        .b(ACC_WIDTH'(in_product)),
        .sum(sum),
        .carry(carry)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc <= '0;
            ovf <= 1'b0;
            beat_count <= '0;
            out_sum <= '0;
            out_overflow <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept && last) begin
                out_sum <= sum;
                out_overflow <= ovf | carry;
                acc <= '0;
                ovf <= 1'b0;
                beat_count <= '0;
                state <= HOLD;
            end else if (accept) begin
                acc <= sum;
                ovf <= ovf | carry;
                beat_count <= beat_count + 8'd1;
            end
        end else if (out_ready) begin
            state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_multiplier_product_accumulator.sv
// tb_multiplier_product_accumulator: scoreboard bench over COUNT=4, narrow-overflow and COUNT=1 instances
module tb_multiplier_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_overflow;
    logic [7:0] in_product = '0, beat_count;
    logic [15:0] out_sum;
    multiplier_product_accumulator #(.PROD_WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .beat_count(beat_count)
    );

    logic o_valid = 1'b0, o_in_ready, o_out_valid, o_overflow;
    logic [7:0] o_product = '0, o_beat_count, o_sum;
    multiplier_product_accumulator #(.PROD_WIDTH(8), .ACC_WIDTH(8), .COUNT(2)) dut_o (
        .clk(clk), .rst(rst), .in_valid(o_valid), .in_ready(o_in_ready), .in_product(o_product),
        .out_valid(o_out_valid), .out_ready(1'b1), .out_sum(o_sum),
        .out_overflow(o_overflow), .beat_count(o_beat_count)
    );

    logic c_valid = 1'b0, c_in_ready, c_out_valid, c_overflow;
    logic [7:0] c_product = '0, c_beat_count;
    logic [15:0] c_sum;
    multiplier_product_accumulator #(.PROD_WIDTH(8), .ACC_WIDTH(16), .COUNT(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_in_ready), .in_product(c_product),
        .out_valid(c_out_valid), .out_ready(1'b1), .out_sum(c_sum),
        .out_overflow(c_overflow), .beat_count(c_beat_count)
    );

    logic [16:0] q_main[$];
    logic [8:0] q_o[$];
    logic [16:0] q_c[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [16:0] e;
            checks++;
            if (q_main.size() == 0) begin
                failures++;
                $display("FAIL main_result unexpected got sum=%0d ovf=%0b", out_sum, out_overflow);
            end else begin
                e = q_main.pop_front();
                if ({out_overflow, out_sum} !== e) begin
                    failures++;
                    $display("FAIL main_result got sum=%0d ovf=%0b exp sum=%0d ovf=%0b", out_sum, out_overflow, e[15:0], e[16]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_out_valid) begin
            logic [8:0] e;
            checks++;
            if (q_o.size() == 0) begin
                failures++;
                $display("FAIL ovf_result unexpected got sum=%0d ovf=%0b", o_sum, o_overflow);
            end else begin
                e = q_o.pop_front();
                if ({o_overflow, o_sum} !== e) begin
                    failures++;
                    $display("FAIL ovf_result got sum=%0d ovf=%0b exp sum=%0d ovf=%0b", o_sum, o_overflow, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid) begin
            logic [16:0] e;
            checks++;
            if (q_c.size() == 0) begin
                failures++;
                $display("FAIL c1_result unexpected got sum=%0d ovf=%0b", c_sum, c_overflow);
            end else begin
                e = q_c.pop_front();
                if ({c_overflow, c_sum} !== e) begin
                    failures++;
                    $display("FAIL c1_result got sum=%0d ovf=%0b exp sum=%0d ovf=%0b", c_sum, c_overflow, e[15:0], e[16]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] p);
        int n = 0;
        in_valid = 1'b1;
        in_product = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%0b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_overflow, beat_count} !== {1'b1, 1'b0, 16'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b vld=%0b sum=%0d ovf=%0b bc=%0d exp 1 0 0 0 0", in_ready, out_valid, out_sum, out_overflow, beat_count);
        end
        checks++;
        if ({o_in_ready, o_out_valid, c_in_ready, c_out_valid} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_aux got %b exp 1010", {o_in_ready, o_out_valid, c_in_ready, c_out_valid});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        q_main.push_back({1'b0, 16'd167});
        send(8'd6); send(8'd30); send(8'd130); send(8'd1);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL basic_latency got vld=%0b rdy=%0b exp vld=1 rdy=0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL basic_one_cycle got vld=%0b rdy=%0b exp vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] beats[4] = '{8'd6, 8'd30, 8'd130, 8'd1};
        q_main.push_back({1'b0, 16'd167});
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (beat_count !== 8'(i)) begin
                failures++;
                $display("FAIL bubble_count_before got %0d exp %0d", beat_count, i);
            end
            send(beats[i]);
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (beat_count !== 8'(i == 3 ? 0 : i + 1)) begin
                failures++;
                $display("FAIL bubble_count_gap got %0d exp %0d", beat_count, i == 3 ? 0 : i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        q_main.push_back({1'b0, 16'd167});
        send(8'd6); send(8'd30); send(8'd130); send(8'd1);
        in_valid = 1'b1;
        in_product = 8'd200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_sum, beat_count} !== {1'b1, 1'b0, 16'd167, 8'd0}) begin
                failures++;
                $display("FAIL hold_stable got vld=%0b rdy=%0b sum=%0d bc=%0d exp 1 0 167 0", out_valid, in_ready, out_sum, beat_count);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        q_main.push_back({1'b0, 16'd287});
        send(8'd26); send(8'd78); send(8'd182); send(8'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send(8'd6); send(8'd30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({beat_count, in_ready} !== {8'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_accum got bc=%0d rdy=%0b exp 0 1", beat_count, in_ready);
        end
        q_main.push_back({1'b0, 16'd4});
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'd9); send(8'd9); send(8'd9); send(8'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ({out_valid, out_sum, out_overflow, in_ready} !== {1'b0, 16'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_hold got vld=%0b sum=%0d ovf=%0b rdy=%0b exp 0 0 0 1", out_valid, out_sum, out_overflow, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
`ifdef ACC_SATURATE_EN
        q_o.push_back({1'b1, 8'd255});
`else
        q_o.push_back({1'b1, 8'd4});
`endif
        q_o.push_back({1'b0, 8'd150});
        o_valid = 1'b1;
        o_product = 8'd130;
        @(posedge clk); #1;
        @(posedge clk); #1;
        o_valid = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_latency got vld=%0b exp 1", o_out_valid);
        end
        @(posedge clk); #1;
        o_valid = 1'b1;
        o_product = 8'd100;
        @(posedge clk); #1;
        o_product = 8'd50;
        @(posedge clk); #1;
        o_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_count1();
        q_c.push_back({1'b0, 16'd169});
        q_c.push_back({1'b0, 16'd2});
        c_valid = 1'b1;
        c_product = 8'd169;
        @(posedge clk); #1;
        checks++;
        if ({c_out_valid, c_in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL c1_first got vld=%0b rdy=%0b exp 1 0", c_out_valid, c_in_ready);
        end
        c_product = 8'd2;
        @(posedge clk); #1;
        checks++;
        if ({c_out_valid, c_in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL c1_return got vld=%0b rdy=%0b exp 0 1", c_out_valid, c_in_ready);
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        checks++;
        if (c_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL c1_second got vld=%0b exp 1", c_out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_count1();
        checks++;
        if (q_main.size() + q_o.size() + q_c.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q_main.size() + q_o.size() + q_c.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
